// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and helpers for the byte-serialising memory
// controller that feeds the instruction-fetch stage.
//   state_e    - controller FSM states
//   len_to_n   - maps a requested byte length onto the number of transfers
package mem_ctrl_pkg;

  localparam int RAM_W = 8;   // RAM port width (one byte)
  localparam int LEN_W = 3;   // width of the byte-length field

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_e;

  // Only 1 and 2 are honoured as short accesses; anything else is a full word.
  function automatic logic [LEN_W-1:0] len_to_n(input logic [LEN_W-1:0] len);
    case (len)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request/response bundle between the IF/MEM stages, the
// controller and the byte-wide RAM.
//   slave  - the controller's view (requests and ram_din in, results out)
//   master - the requester/RAM-side view
interface mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import mem_ctrl_pkg::*;

  logic              jmp;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] inst_o;
  logic              inst_ok;
  logic              mem_req;
  logic              mem_we;
  logic [LEN_W-1:0]  mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ok;
  logic [RAM_W-1:0]  ram_din;
  logic [RAM_W-1:0]  ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;

  modport slave (
    input  jmp, if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    output inst_o, inst_ok, mem_rdata, mem_ok, ram_dout, ram_a, ram_wr
  );

  modport master (
    output jmp, if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    input  inst_o, inst_ok, mem_rdata, mem_ok, ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_byte_assembler.sv
// mem_byte_assembler: byte counter k plus little-endian word assembly.
//   i_start    - clear k and the word (new transfer accepted)
//   i_step     - advance k; when k>0 the byte on i_din is byte k-1
//   i_din      - RAM read byte
//   o_k        - current byte counter
//   o_word_nxt - word with i_din already inserted at byte k-1, so the final
//                byte can be forwarded to the result register without an
//                extra capture cycle
module mem_byte_assembler
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_step,
  input  logic [RAM_W-1:0]  i_din,
  output logic [LEN_W-1:0]  o_k,
  output logic [DATA_W-1:0] o_word_nxt
);

  logic [LEN_W-1:0]  r_k;
  logic [DATA_W-1:0] r_word;
  logic [1:0]        w_idx;

  // k in 1..4 -> byte lane 0..3 (k=4 wraps to lane 3 in two bits)
  assign w_idx = r_k[1:0] - 2'd1;

  always_comb begin
    o_word_nxt = r_word;
    if (r_k != '0) o_word_nxt[{w_idx, 3'b000} +: RAM_W] = i_din;
  end

  always_ff @(posedge clk) begin
    if (rst || i_start) begin
      r_k    <= '0;
      r_word <= '0;   // zero-extension of short loads comes from this clear
    end else if (i_step) begin
      r_k    <= r_k + 3'd1;
      r_word <= o_word_nxt;
    end
  end

  assign o_k = r_k;

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates IF fetches and MEM loads/stores onto one byte-wide
// synchronous RAM, serialising each access into byte transfers.
//   clk, rst - clock, synchronous active-high reset
//   bus      - mem_ctrl_if.slave: jmp, IF request/inst result,
//              MEM request/rdata result, RAM byte port
// Timing: the accepting edge presents byte 0's address; byte k's data is
// captured one cycle after its address; ok rises N+1 edges after accept.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_ctrl_if.slave    bus
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_n;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_inst;
  logic              r_inst_ok;
  logic [DATA_W-1:0] r_rdata;
  logic              r_mem_ok;
  logic [ADDR_W-1:0] r_ram_a;
  logic [RAM_W-1:0]  r_ram_dout;
  logic              r_ram_wr;

  logic [LEN_W-1:0]  w_k;
  logic [LEN_W-1:0]  w_k_nxt;
  logic [DATA_W-1:0] w_word_nxt;
  logic              w_free;
  logic              w_accept_mem;
  logic              w_accept_if;
  logic              w_abort;
  logic              w_last;
  logic              w_step;
  logic              w_wr_nxt;

  // An ok still on display blocks acceptance so a held req is not re-served.
  assign w_free       = (r_state == IDLE) && !r_inst_ok && !r_mem_ok;
  assign w_accept_mem = w_free && bus.mem_req;
  assign w_accept_if  = w_free && !bus.mem_req && bus.if_req && !bus.jmp;
  assign w_abort      = (r_state == IF_RD) && bus.jmp;
  assign w_last       = (r_state != IDLE) && (w_k == r_n);
  assign w_step       = (r_state != IDLE) && !w_abort && !w_last;
  assign w_k_nxt      = w_k + 3'd1;
  assign w_wr_nxt     = (r_state == MEM_WR) && (w_k_nxt < r_n);

  mem_byte_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_accept_mem || w_accept_if),
    .i_step     (w_step),
    .i_din      (bus.ram_din),
    .o_k        (w_k),
    .o_word_nxt (w_word_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_base     <= '0;
      r_n        <= '0;
      r_wdata    <= '0;
      r_inst     <= '0;
      r_inst_ok  <= 1'b0;
      r_rdata    <= '0;
      r_mem_ok   <= 1'b0;
      r_ram_a    <= '0;
      r_ram_dout <= '0;
      r_ram_wr   <= 1'b0;
    end else begin
      r_inst_ok <= 1'b0;
      r_mem_ok  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ram_a    <= '0;
          r_ram_wr   <= 1'b0;
          r_ram_dout <= '0;
          if (w_accept_mem) begin
            r_state    <= bus.mem_we ? MEM_WR : MEM_RD;
            r_base     <= bus.mem_addr;
            r_n        <= len_to_n(bus.mem_len);
            r_wdata    <= bus.mem_wdata;
            r_ram_a    <= bus.mem_addr;
            r_ram_wr   <= bus.mem_we;
            r_ram_dout <= bus.mem_we ? bus.mem_wdata[RAM_W-1:0] : '0;
          end else if (w_accept_if) begin
            r_state <= IF_RD;
            r_base  <= bus.if_addr;
            r_n     <= 3'd4;
            r_ram_a <= bus.if_addr;
          end
        end
        default: begin
          if (w_abort) begin
            r_state    <= IDLE;
            r_ram_a    <= '0;
            r_ram_wr   <= 1'b0;
            r_ram_dout <= '0;
          end else if (w_last) begin
            // k==N: last byte is on ram_din now (reads) or the write tail ends
            r_state    <= IDLE;
            r_ram_a    <= '0;
            r_ram_wr   <= 1'b0;
            r_ram_dout <= '0;
            if (r_state == IF_RD) begin
              r_inst_ok <= 1'b1;
              r_inst    <= w_word_nxt;
            end else begin
              r_mem_ok <= 1'b1;
              if (r_state == MEM_RD) r_rdata <= w_word_nxt;
            end
          end else begin
            r_ram_a    <= r_base + ADDR_W'(w_k_nxt);
            r_ram_wr   <= w_wr_nxt;
            r_ram_dout <= w_wr_nxt ? r_wdata[{w_k_nxt[1:0], 3'b000} +: RAM_W] : '0;
          end
        end
      endcase
    end
  end

  assign bus.inst_o    = r_inst;
  assign bus.inst_ok   = r_inst_ok;
  assign bus.mem_rdata = r_rdata;
  assign bus.mem_ok    = r_mem_ok;
  assign bus.ram_a     = r_ram_a;
  assign bus.ram_dout  = r_ram_dout;
  assign bus.ram_wr    = r_ram_wr;

endmodule
